// File: rtl/fpadd_issue_if.sv
// fpadd_issue_if: signal bundle between the operand-issue stage and its environment.
//   in_*   : operand-pair stream into the issue FIFO (valid/ready)
//   out_*  : result stream out of the issue stage (valid/ready, err flag)
//   add_*  : start/operand/done/sum handshake with the multi-cycle adder
// Modports:
//   slave  : the issue stage itself
//   master : the environment (operand source, result sink, adder)
interface fpadd_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_err;

    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_done;
    logic [31:0] add_sum;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, add_done, add_sum,
        output in_ready, out_valid, out_sum, out_err, add_start, add_a, add_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, add_done, add_sum,
        input  in_ready, out_valid, out_sum, out_err, add_start, add_a, add_b
    );
endinterface

// File: rtl/fpadd_issue.sv
// fpadd_issue: operand-issue stage in front of the multi-cycle FP adder.
// Buffers operand pairs in a FIFO, issues one add at a time with a single-cycle
// start pulse and stable operands, waits for done under a watchdog, and holds
// each result in a registered valid/ready output. A hung adder yields a quiet
// NaN flagged with out_err.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-low reset
//   bus      : fpadd_issue_if.slave (operand stream, result stream, adder handshake)
//   busy     : FSM is not idle
//   count    : FIFO occupancy
//   err_cnt  : saturating count of watchdog events
module fpadd_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    fpadd_issue_if.slave  bus,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic [7:0]    err_cnt
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned TW   = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t         state;
    logic [31:0]    mem_a [DEPTH];
    logic [31:0]    mem_b [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [TW-1:0]  timer;
    logic           push;
    logic           pop;

    // Ready depends on occupancy only, never on the output side.
    assign bus.in_ready = (count != CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    // Issue only when no result is pending, so at most one result is in flight.
    assign pop          = (state == IDLE) && (count != '0) && !bus.out_valid;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    // Pointers, occupancy, issue FSM, watchdog and output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            timer         <= '0;
            err_cnt       <= '0;
            bus.add_start <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            bus.add_start <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.add_a     <= mem_a[rd_ptr];
                        bus.add_b     <= mem_b[rd_ptr];
                        bus.add_start <= 1'b1;
                        timer         <= '0;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // done takes priority over a watchdog expiring in the same cycle
                    if (bus.add_done) begin
                        bus.out_sum   <= bus.add_sum;
                        bus.out_err   <= 1'b0;
                        bus.out_valid <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.out_sum   <= QNAN;
                        bus.out_err   <= 1'b1;
                        bus.out_valid <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/fpadd_issue.md
# fpadd_issue

Operand-issue stage placed directly upstream of the multi-cycle floating-point adder (`fpadd`). It accepts IEEE-754 single-precision operand pairs over a valid/ready stream and buffers them in a small FIFO. It then drives the adder's `start`/`a`/`b` inputs one operation at a time, waits for `done` under a watchdog, and presents each sum on a registered valid/ready output. The block serialises traffic, guarantees a clean single-cycle `start` pulse with stable operands, and converts a hung adder into a flagged NaN result.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 64: maximum WAIT cycles before the watchdog fires; minimum 2.
- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  FIFO can accept a pair; equals `count != DEPTH`.
- `in_a`, `in_b`  input  32  operands, IEEE-754 single.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `out_sum`  output  32  result.
- `out_err`  output  1  result produced by the watchdog, not by the adder.
- `add_start`  output  1  start pulse to adder.
- `add_a`, `add_b`  output  32  operands to adder; registered.
- `add_done`  input  1  adder done; level, held until the next start.
- `add_sum`  input  32  adder result; valid while `add_done`=1.
- `busy`  output  1  FSM not in IDLE.
- `count`  output  clog2(DEPTH)+1  FIFO occupancy.
- `err_cnt`  output  8  saturating count of watchdog events.

## Operation
- **FIFO.** A push happens when `in_valid & in_ready`. A pop is performed only by the FSM in IDLE. Push and pop in the same cycle leave `count` unchanged. Read and write pointers wrap modulo DEPTH. Data pushed into an empty FIFO is not poppable until the following cycle; there is no bypass.
- **IDLE.** If `count != 0` and `out_valid == 0`:
  - pop the head into `add_a`/`add_b`;
  - clear `timer`;
  - go to ISSUE.
- **ISSUE.** `add_start` = 1 for exactly this one cycle, then go to WAIT. `add_a`/`add_b` stay stable from the pop until the next pop.
- **WAIT.** `timer` increments each cycle.
  - If `add_done` = 1: `out_sum <= add_sum`, `out_err <= 0`, `out_valid <= 1`, go to IDLE.
  - Otherwise, if `timer == TIMEOUT-1`: `out_sum <= 32'h7FC00000`, `out_err <= 1`, `out_valid <= 1`, `err_cnt` increments (saturating at 255), go to IDLE.
  - If `add_done` and the timeout occur in the same cycle, `add_done` wins.
- **Output register.** `out_valid` clears on `out_valid & out_ready`. `out_sum`/`out_err` hold while `out_valid` = 1 and `out_ready` = 0. No new operation is issued while a result is pending; at most one result is in flight.
- **Stale done.** `add_done` is sampled only in WAIT. Because the adder clears `done` on the edge at which it samples `start`, WAIT never sees the previous operation's `done`.
- **Reset** (`reset` = 0 at an edge), from any state including mid-WAIT:
  - state → IDLE; FIFO emptied (`count` = 0, pointers = 0);
  - `in_ready` → 1; `out_valid`, `out_err`, `add_start`, `busy` → 0;
  - `out_sum`, `add_a`, `add_b`, `err_cnt`, `timer` → 0.
  - The adder is not separately aborted. Its stale `done` is ignored because the next operation passes through ISSUE first.

## Timing
- Accept at edge E into an idle, empty block:
  - pop at E+1;
  - `add_start` high during the cycle after E+1, sampled by the adder at E+2;
  - WAIT from E+2.
- If `add_done` is first high at WAIT edge D, `out_valid` is high from D+1.
- Watchdog: `out_valid` rises exactly TIMEOUT+1 edges after the ISSUE edge when `add_done` never asserts.
- Throughput: one result per (3 + adder latency + handshake) cycles at most; the back-to-back issue gap is ≥1 IDLE cycle.
- `in_ready` is combinational from `count` only, with no dependency on `out_ready`.

## Test plan
- Idle block; push `3F800000`+`40000000` with a behavioural adder (done after 6 cycles, sum `40400000`). Required: one `add_start` pulse, `out_sum = 40400000`, `out_err = 0`, `count` back to 0.
- Push 6 pairs back-to-back with `out_ready` = 1 and DEPTH = 4. Required: `in_ready` low while `count = 4`, all 6 sums in order, exactly 6 `add_start` pulses, `add_a`/`add_b` stable throughout each WAIT.
- Adder stub never asserts `add_done`. Required: result `7FC00000` with `out_err = 1` exactly TIMEOUT+1 edges after ISSUE, `err_cnt = 1`, next queued pair then issues normally.
- Hold `out_ready` = 0 after the first result with 3 pairs queued. Required: `out_sum` stable, no further `add_start`, `count = 3`; releasing `out_ready` resumes issuing.
- Push in the same cycle as a pop at `count = 2`. Required: `count` stays 2, FIFO order preserved.
- Assert `reset` low during WAIT with 2 pairs queued and a stale `add_done` = 1. Required: all outputs at reset values, `count = 0`; a new pair afterwards completes correctly, with the stale `done` not captured before ISSUE.
